uart_tx_array: RTL and testbench

- Parametrised multi-channel UART transmitter; successor to the fixed 8-bit, per-channel PISO UART instances.
- Each instance shares one baud divider, one frame state machine and one valid/ready load handshake across NCH serial lanes.
- Sits between pixel/stencil datapaths and the J3 header pins.
- Adds what the old block lacks: a configurable data width, stop-bit count and baud divisor, a per-channel enable mask, backpressure, and a done pulse.

---
 rtl/uart_tx_array.sv | 154 +++++++++++++++
 tb/tb_uart_tx_array.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_array.sv
// Multi-lane UART transmitter: one baud divider, frame FSM and valid/ready load shared by NCH serial lanes.
// Optional parity bit after the data MSB is enabled by defining UART_TX_ARRAY_PARITY_EN.
module uart_tx_array #(
  parameter int NCH       = 7,
  parameter int DATA_W    = 8,
  parameter int BAUD_DIV  = 103,
  parameter int STOP_BITS = 1
`ifdef UART_TX_ARRAY_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [NCH*DATA_W-1:0] IN_DATA,
  input  logic [NCH-1:0]        IN_MASK,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  output logic [NCH-1:0]        TX,
  output logic                  BUSY,
  output logic                  DONE
);

`ifdef UART_TX_ARRAY_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int NBITS = 1 + DATA_W + PAR_BITS + STOP_BITS;
  localparam int BCW   = $clog2(BAUD_DIV);
  localparam int NBW   = $clog2(NBITS);
  localparam logic [BCW-1:0] BAUD_LAST = BCW'(BAUD_DIV - 1);
  localparam logic [NBW-1:0] BIT_LAST  = NBW'(NBITS - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q, state_d;

  logic [1:0]                    rst_sync_q;
  logic [BCW-1:0]                baud_q;
  logic [NBW-1:0]                bit_q;
  logic [NCH-1:0]                mask_q;
  logic [NCH-1:0][NBITS-2:0]     shreg_q;
  logic [NCH-1:0][NBITS-2:0]     load_w;
  logic [NCH-1:0]                tx_q;
  logic                          busy_q;
  logic                          done_q;
  logic                          load;
  logic                          baud_last;
  logic                          frame_end;

  // The start bit is driven straight from the load, so the shift register only holds the remaining bits.
  always_comb begin
    load_w = '0;
    for (int k = 0; k < NCH; k++) begin
`ifdef UART_TX_ARRAY_PARITY_EN
      load_w[k] = {{STOP_BITS{1'b1}},
                   (^IN_DATA[k*DATA_W +: DATA_W]) ^ (PARITY_ODD != 0),
                   IN_DATA[k*DATA_W +: DATA_W]};
`else
      load_w[k] = {{STOP_BITS{1'b1}}, IN_DATA[k*DATA_W +: DATA_W]};
`endif
    end
  end

  // Reset release is synchronised so the first handshake can never race the deassertion edge.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign IN_READY  = (state_q == IDLE) && rst_sync_q[1];
  assign baud_last = (baud_q == BAUD_LAST);

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    frame_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (IN_VALID && IN_READY) begin
          load    = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (baud_last && (bit_q == BIT_LAST)) begin
          frame_end = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Masked-off lanes are forced high for the whole frame while timing still runs normally.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      baud_q  <= '0;
      bit_q   <= '0;
      mask_q  <= '0;
      shreg_q <= '1;
      tx_q    <= '1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        shreg_q <= load_w;
        mask_q  <= IN_MASK;
        baud_q  <= '0;
        bit_q   <= '0;
        busy_q  <= 1'b1;
        tx_q    <= ~IN_MASK;
      end else if (state_q == SHIFT) begin
        if (frame_end) begin
          baud_q <= '0;
          bit_q  <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          tx_q   <= '1;
        end else if (baud_last) begin
          baud_q <= '0;
          bit_q  <= bit_q + 1'b1;
          for (int k = 0; k < NCH; k++) begin
            tx_q[k]    <= shreg_q[k][0] | ~mask_q[k];
            shreg_q[k] <= {1'b1, shreg_q[k][NBITS-2:1]};
          end
        end else begin
          baud_q <= baud_q + 1'b1;
        end
      end
    end
  end

  assign TX   = tx_q;
  assign BUSY = busy_q;
  assign DONE = done_q;

endmodule

// File: tb/tb_uart_tx_array.sv
// Directed bench for uart_tx_array: two small instances (4-cycle bits / 1 stop, 3-cycle bits / 2 stops).
// Expected frames are hand-computed; parity variants apply when UART_TX_ARRAY_PARITY_EN is defined.
module tb_uart_tx_array;

`ifdef UART_TX_ARRAY_PARITY_EN
  localparam int NB_A = 11;
  localparam int NB_B = 12;
  localparam int LOW_M10 = 40;
  localparam logic [15:0] EXP_55 = 16'h04AA, EXP_A3 = 16'h0546, EXP_34 = 16'h0668, EXP_12 = 16'h0424;
  localparam logic [15:0] EXP_CB = 16'h0796, EXP_ED = 16'h05DA, EXP_FF = 16'h05FE;
`else
  localparam int NB_A = 10;
  localparam int NB_B = 11;
  localparam int LOW_M10 = 36;
  localparam logic [15:0] EXP_55 = 16'h02AA, EXP_A3 = 16'h0346, EXP_34 = 16'h0268, EXP_12 = 16'h0224;
  localparam logic [15:0] EXP_CB = 16'h0396, EXP_ED = 16'h03DA, EXP_FF = 16'h03FE;
`endif

  logic        CLK;
  logic        RESETN;
  logic [15:0] a_data, b_data;
  logic [1:0]  a_mask, b_mask;
  logic        a_valid, b_valid;
  logic        a_ready, b_ready;
  logic [1:0]  a_tx, b_tx;
  logic        a_busy, b_busy;
  logic        a_done, b_done;

  int total = 0;
  int bad   = 0;

  logic [15:0] s0, s1;
  int busy_cnt, done_at, ready_cnt, low0, low1, last_low0, done_seen;

  uart_tx_array #(
    .NCH(2), .DATA_W(8), .BAUD_DIV(4), .STOP_BITS(1)
`ifdef UART_TX_ARRAY_PARITY_EN
    , .PARITY_ODD(0)
`endif
  ) dut_a (
    .CLK(CLK), .RESETN(RESETN), .IN_DATA(a_data), .IN_MASK(a_mask), .IN_VALID(a_valid),
    .IN_READY(a_ready), .TX(a_tx), .BUSY(a_busy), .DONE(a_done)
  );

  uart_tx_array #(
    .NCH(2), .DATA_W(8), .BAUD_DIV(3), .STOP_BITS(2)
`ifdef UART_TX_ARRAY_PARITY_EN
    , .PARITY_ODD(1)
`endif
  ) dut_b (
    .CLK(CLK), .RESETN(RESETN), .IN_DATA(b_data), .IN_MASK(b_mask), .IN_VALID(b_valid),
    .IN_READY(b_ready), .TX(b_tx), .BUSY(b_busy), .DONE(b_done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int sel, input logic [15:0] data, input logic [1:0] mask,
                                input logic valid);
    if (sel == 0) begin
      a_data = data; a_mask = mask; a_valid = valid;
    end else begin
      b_data = data; b_mask = mask; b_valid = valid;
    end
  endtask

  // First tick is the transfer edge; afterwards inputs are scrambled to prove the frame was latched.
  task automatic record_frame(input int sel, input logic keep_valid,
                              output logic [15:0] r0, output logic [15:0] r1,
                              output int n_busy, output int n_done_at, output int n_ready,
                              output int n_low0, output int n_low1, output int n_last_low0);
    int bd;
    logic [1:0] tx;
    logic busy, done, rdy;
    bd = (sel == 0) ? 4 : 3;
    r0 = '0; r1 = '0;
    n_busy = 0; n_done_at = 0; n_ready = 0; n_low0 = 0; n_low1 = 0; n_last_low0 = 0;
    tick();
    if (sel == 0) begin
      a_valid = keep_valid;
      a_data  = ~a_data;
      if (!keep_valid) a_mask = ~a_mask;
    end else begin
      b_valid = keep_valid;
      b_data  = ~b_data;
      if (!keep_valid) b_mask = ~b_mask;
    end
    for (int c = 1; c <= 200; c++) begin
      tx   = (sel == 0) ? a_tx : b_tx;
      busy = (sel == 0) ? a_busy : b_busy;
      done = (sel == 0) ? a_done : b_done;
      rdy  = (sel == 0) ? a_ready : b_ready;
      if (busy) n_busy++;
      if (rdy) n_ready++;
      if (!tx[0]) begin
        n_low0++;
        n_last_low0 = c;
      end
      if (!tx[1]) n_low1++;
      if (((c - 1) % bd == 1) && ((c - 1) / bd < 16)) begin
        r0[(c - 1) / bd] = tx[0];
        r1[(c - 1) / bd] = tx[1];
      end
      if (done) begin
        n_done_at = c;
        break;
      end
      tick();
    end
  endtask

  initial begin
    RESETN = 1'b1;
    apply_stimulus(0, 16'h0000, 2'b00, 1'b0);
    apply_stimulus(1, 16'h0000, 2'b00, 1'b0);
    #2;
    RESETN = 1'b0;
    #1;
    check_output("reset_tx", 32'(a_tx), 32'h3);
    check_output("reset_busy", 32'(a_busy), 32'h0);
    check_output("reset_done", 32'(a_done), 32'h0);
    check_output("reset_ready_held", 32'(a_ready), 32'h0);
    repeat (3) tick();
    RESETN = 1'b1;
    repeat (3) tick();
    check_output("ready_after_release", 32'(a_ready), 32'h1);
    check_output("b_ready_after_release", 32'(b_ready), 32'h1);

    // Basic frame: lane0 = 0x55, lane1 = 0xA3.
    apply_stimulus(0, {8'hA3, 8'h55}, 2'b11, 1'b1);
    record_frame(0, 1'b0, s0, s1, busy_cnt, done_at, ready_cnt, low0, low1, last_low0);
    check_output("f1_lane0_bits", 32'(s0), 32'(EXP_55));
    check_output("f1_lane1_bits", 32'(s1), 32'(EXP_A3));
    check_output("f1_busy_cycles", 32'(busy_cnt), 32'(NB_A * 4));
    check_output("f1_done_cycle", 32'(done_at), 32'(NB_A * 4 + 1));
    check_output("f1_ready_count", 32'(ready_cnt), 32'h1);
    check_output("f1_idle_tx", 32'(a_tx), 32'h3);
    tick();
    check_output("f1_done_width", 32'(a_done), 32'h0);

    // Back-to-back with IN_VALID held; data flips to ~D1 right after the first transfer.
    apply_stimulus(0, {8'h12, 8'h34}, 2'b11, 1'b1);
    record_frame(0, 1'b1, s0, s1, busy_cnt, done_at, ready_cnt, low0, low1, last_low0);
    check_output("b2b1_lane0_bits", 32'(s0), 32'(EXP_34));
    check_output("b2b1_lane1_bits", 32'(s1), 32'(EXP_12));
    check_output("b2b1_ready_count", 32'(ready_cnt), 32'h1);
    check_output("b2b1_done_cycle", 32'(done_at), 32'(NB_A * 4 + 1));
    check_output("b2b_gap_tx", 32'(a_tx), 32'h3);
    record_frame(0, 1'b0, s0, s1, busy_cnt, done_at, ready_cnt, low0, low1, last_low0);
    check_output("b2b2_lane0_bits", 32'(s0), 32'(EXP_CB));
    check_output("b2b2_lane1_bits", 32'(s1), 32'(EXP_ED));
    check_output("b2b2_period", 32'(done_at), 32'(NB_A * 4 + 1));
    tick();
    check_output("b2b_no_third_busy", 32'(a_busy), 32'h0);

    // Mask 2'b10 with all-zero data.
    apply_stimulus(0, 16'h0000, 2'b10, 1'b1);
    record_frame(0, 1'b0, s0, s1, busy_cnt, done_at, ready_cnt, low0, low1, last_low0);
    check_output("m10_lane0_low", 32'(low0), 32'h0);
    check_output("m10_lane1_low", 32'(low1), 32'(LOW_M10));
    check_output("m10_done_cycle", 32'(done_at), 32'(NB_A * 4 + 1));

    // Mask all zeros: full-length frame, both lines high.
    apply_stimulus(0, 16'h0000, 2'b00, 1'b1);
    record_frame(0, 1'b0, s0, s1, busy_cnt, done_at, ready_cnt, low0, low1, last_low0);
    check_output("m00_low", 32'(low0 + low1), 32'h0);
    check_output("m00_busy_cycles", 32'(busy_cnt), 32'(NB_A * 4));
    check_output("m00_done_cycle", 32'(done_at), 32'(NB_A * 4 + 1));

    // Reset asserted at cycle 15 of a frame.
    apply_stimulus(0, 16'h0000, 2'b11, 1'b1);
    tick();
    a_valid = 1'b0;
    repeat (14) tick();
    check_output("midrst_tx_before", 32'(a_tx), 32'h0);
    RESETN = 1'b0;
    #1;
    check_output("midrst_tx_async", 32'(a_tx), 32'h3);
    check_output("midrst_busy", 32'(a_busy), 32'h0);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (a_done) done_seen++;
    end
    RESETN = 1'b1;
    tick();
    if (a_done) done_seen++;
    check_output("midrst_ready_sync", 32'(a_ready), 32'h0);
    repeat (2) tick();
    if (a_done) done_seen++;
    check_output("midrst_no_done", 32'(done_seen), 32'h0);
    check_output("midrst_ready_back", 32'(a_ready), 32'h1);
    apply_stimulus(0, 16'hFFFF, 2'b11, 1'b1);
    record_frame(0, 1'b0, s0, s1, busy_cnt, done_at, ready_cnt, low0, low1, last_low0);
    check_output("postrst_lane0_bits", 32'(s0), 32'(EXP_FF));
    check_output("postrst_lane1_bits", 32'(s1), 32'(EXP_FF));
    check_output("postrst_done_cycle", 32'(done_at), 32'(NB_A * 4 + 1));

    // Two stop bits, 3-cycle bits: start + 8 zero data bits low, then the tail is high.
    apply_stimulus(1, 16'h0000, 2'b11, 1'b1);
    record_frame(1, 1'b0, s0, s1, busy_cnt, done_at, ready_cnt, low0, low1, last_low0);
    check_output("sb2_busy_cycles", 32'(busy_cnt), 32'(NB_B * 3));
    check_output("sb2_done_cycle", 32'(done_at), 32'(NB_B * 3 + 1));
    check_output("sb2_low_cycles", 32'(low0), 32'd27);
    check_output("sb2_last_low", 32'(last_low0), 32'd27);

`ifdef UART_TX_ARRAY_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0, in the 10th slot.
    apply_stimulus(0, 16'h0707, 2'b11, 1'b1);
    record_frame(0, 1'b0, s0, s1, busy_cnt, done_at, ready_cnt, low0, low1, last_low0);
    check_output("par_even_bit", 32'(s0[9]), 32'h1);
    check_output("par_even_len", 32'(done_at), 32'd45);
    apply_stimulus(1, 16'h0707, 2'b11, 1'b1);
    record_frame(1, 1'b0, s0, s1, busy_cnt, done_at, ready_cnt, low0, low1, last_low0);
    check_output("par_odd_bit", 32'(s0[9]), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
